// File: rtl/game_session_ctrl_if.sv
// Bundle of the per-frame game inputs and the session status outputs of
// game_session_ctrl; the player generators drive it as master.
interface game_session_ctrl_if #(
  parameter int NUM_PLAYERS = 4,
  parameter int LOC_W       = 9,
  parameter int SCORE_W     = 8
);
  logic                           tick_i;
  logic                           new_game_i;
  logic [NUM_PLAYERS-1:0]         player_en_i;
  logic [NUM_PLAYERS*LOC_W-1:0]   luc_loc_i;
  logic [1:0]                     state_o;
  logic                           lines_run_o;
  logic [3:0]                     countdown_o;
  logic [NUM_PLAYERS-1:0]         alive_o;
  logic [NUM_PLAYERS*SCORE_W-1:0] score_o;
  logic [2:0]                     winner_o;
  logic                           winner_valid_o;

  modport master (
    output tick_i, new_game_i, player_en_i, luc_loc_i,
    input  state_o, lines_run_o, countdown_o, alive_o, score_o, winner_o, winner_valid_o
  );

  modport slave (
    input  tick_i, new_game_i, player_en_i, luc_loc_i,
    output state_o, lines_run_o, countdown_o, alive_o, score_o, winner_o, winner_valid_o
  );
endinterface

// File: rtl/game_session_ctrl.sv
// Round/score controller for the N-player gravity runner: IDLE -> COUNTDOWN
// -> RUN -> OVER, with playfield eliminations, saturating scores and a winner.
module game_session_ctrl #(
  parameter int NUM_PLAYERS     = 4,
  parameter int LOC_W           = 9,
  parameter int SCORE_W         = 8,
  parameter int KILL_TOP        = 0,
  parameter int KILL_BOTTOM     = 440,
  parameter int COUNTDOWN_TICKS = 3
) (
  input logic                clk_i,
  input logic                rst_i,
  game_session_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_RUN       = 2'd2,
    S_OVER      = 2'd3
  } state_t;

  localparam logic [LOC_W-1:0] KILL_TOP_L    = LOC_W'(KILL_TOP);
  localparam logic [LOC_W-1:0] KILL_BOTTOM_L = LOC_W'(KILL_BOTTOM);
  localparam logic [3:0]       CD_INIT       = 4'(COUNTDOWN_TICKS);

  function automatic logic [3:0] popcnt(input logic [NUM_PLAYERS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) n = n + {3'b000, v[k]};
    return n;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + SCORE_W'(1);
  endfunction

  state_t                     state;
  logic                       ng_q;
  logic [NUM_PLAYERS-1:0]     active;
  logic [NUM_PLAYERS-1:0]     alive;
  logic [NUM_PLAYERS*SCORE_W-1:0] score;
  logic [3:0]                 countdown;
  logic [2:0]                 winner;
  logic                       winner_valid;
  logic                       lines_run;

  logic                       ng_edge;
  logic                       start_round;
  logic [NUM_PLAYERS-1:0]     kill;
  logic [NUM_PLAYERS-1:0]     next_alive;
  logic                       multi;
  logic                       run_end;
  logic [2:0]                 win_idx;

  assign ng_edge     = bus.new_game_i & ~ng_q;
  // A new round can be armed from any state except RUN, and only with players.
  assign start_round = ng_edge & (|bus.player_en_i) & (state != S_RUN);

  always_comb begin
    kill = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      kill[k] = alive[k] &
                ((bus.luc_loc_i[k*LOC_W +: LOC_W] <= KILL_TOP_L) |
                 (bus.luc_loc_i[k*LOC_W +: LOC_W] >= KILL_BOTTOM_L));
    end
  end

  assign next_alive = alive & ~kill;
  assign multi      = (popcnt(active) >= 4'd2);
  assign run_end    = multi ? (popcnt(next_alive) <= 4'd1) : (next_alive == '0);

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      if (next_alive[k]) win_idx = 3'(k);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= S_IDLE;
      ng_q         <= 1'b0;
      active       <= '0;
      alive        <= '0;
      score        <= '0;
      countdown    <= '0;
      winner       <= '0;
      winner_valid <= 1'b0;
      lines_run    <= 1'b0;
    end else begin
      ng_q <= bus.new_game_i;
      if (start_round) begin
        state        <= S_COUNTDOWN;
        lines_run    <= 1'b0;
        countdown    <= CD_INIT;
        active       <= bus.player_en_i;
        alive        <= bus.player_en_i;
        score        <= '0;
        winner       <= '0;
        winner_valid <= 1'b0;
      end else begin
        case (state)
          S_COUNTDOWN: begin
            if (bus.tick_i) begin
              if (countdown <= 4'd1) begin
                state     <= S_RUN;
                lines_run <= 1'b1;
                countdown <= '0;
              end else begin
                countdown <= countdown - 4'd1;
              end
            end
          end
          S_RUN: begin
            alive <= next_alive;
            // Only players surviving this cycle's kill check earn the tick.
            if (bus.tick_i) begin
              for (int k = 0; k < NUM_PLAYERS; k++) begin
                if (next_alive[k])
                  score[k*SCORE_W +: SCORE_W] <= sat_inc(score[k*SCORE_W +: SCORE_W]);
              end
            end
            if (run_end) begin
              state        <= S_OVER;
              lines_run    <= 1'b0;
              winner_valid <= multi & (popcnt(next_alive) == 4'd1);
              winner       <= (multi & (popcnt(next_alive) == 4'd1)) ? win_idx : 3'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.state_o        = state;
  assign bus.lines_run_o    = lines_run;
  assign bus.countdown_o    = countdown;
  assign bus.alive_o        = alive;
  assign bus.score_o        = score;
  assign bus.winner_o       = winner;
  assign bus.winner_valid_o = winner_valid;

endmodule
